// File: rtl/ts_pkg.sv
// Shared constants, symbol-index type and FSM state encoding for the ts_os_gen training-set generator.
package ts_pkg;
    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] SKP    = 8'h1C;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef logic [3:0] sym_idx_t;

    localparam sym_idx_t SYM_LAST = 4'd15;
    localparam sym_idx_t SKP_LAST = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_SKP,
        ST_DONE
    } state_t;
endpackage

// File: rtl/ts_lane_sym.sv
// Per-lane symbol mux: maps symbol index plus captured training-set fields to one lane's data byte and K flag.
module ts_lane_sym
    import ts_pkg::*;
(
    input  logic [3:0] idx,
    input  logic       skp_os,
    input  logic       ts_type,
    input  logic [7:0] link_num,
    input  logic       link_pad,
    input  logic       lane_pad,
    input  logic [7:0] lane_id,
    input  logic [7:0] n_fts,
    input  logic [7:0] rate_id,
    input  logic [7:0] train_ctl,
    output logic [7:0] data,
    output logic       k
);
    always_comb begin
        data = ts_type ? TS2_ID : TS1_ID;
        k    = 1'b0;
        if (skp_os) begin
            data = (idx == 4'd0) ? COM : SKP;
            k    = 1'b1;
        end else begin
            case (idx)
                4'd0: begin
                    data = COM;
                    k    = 1'b1;
                end
                4'd1: begin
                    data = link_pad ? PAD : link_num;
                    k    = link_pad;
                end
                4'd2: begin
                    data = lane_pad ? PAD : lane_id;
                    k    = lane_pad;
                end
                4'd3:    data = n_fts;
                4'd4:    data = rate_id;
                4'd5:    data = train_ctl;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ts_os_gen.sv
// Multi-lane PCIe TS1/TS2 ordered-set generator with start/busy/done control and valid/ready symbol output.
// Optional SKP ordered-set insertion is enabled by defining TS_OS_GEN_SKP_EN.
module ts_os_gen
    import ts_pkg::*;
#(
    parameter int LANE_NUM     = 4,
    parameter int CNT_W        = 16,
    parameter int SKP_INTERVAL = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ts_start,
    input  logic                  ts_type,
    input  logic [CNT_W-1:0]      ts_count,
    input  logic                  ts_stop,
    input  logic [7:0]            link_num,
    input  logic                  link_pad,
    input  logic                  lane_pad,
    input  logic                  lane_rev,
    input  logic [7:0]            n_fts,
    input  logic [7:0]            rate_id,
    input  logic [7:0]            train_ctl,
    output logic                  ts_busy,
    output logic                  ts_done,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic [LANE_NUM*8-1:0] sym_data,
    output logic [LANE_NUM-1:0]   sym_k,
    output logic                  sym_sos
);
    state_t           state, state_nx;
    sym_idx_t         idx;
    logic [CNT_W-1:0] os_cnt;
    logic [CNT_W-1:0] os_cnt_inc;
    logic             stop_q;
    logic             accept, fire, os_end, last_os;

    logic             type_q, link_pad_q, lane_pad_q, lane_rev_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       link_q, nfts_q, rate_q, ctl_q;

    assign accept     = (state == ST_IDLE) && ts_start;
    assign sym_valid  = (state == ST_SEND) || (state == ST_SKP);
    assign ts_busy    = (state != ST_IDLE);
    assign ts_done    = (state == ST_DONE);
    assign sym_sos    = sym_valid && (idx == 4'd0);
    assign fire       = sym_valid && sym_ready;
    assign os_end     = fire && (state == ST_SEND) && (idx == SYM_LAST);
    // Continuous mode relies on the saturating increment never wrapping back to a small count.
    assign os_cnt_inc = (os_cnt == '1) ? os_cnt : os_cnt + 1'b1;
    assign last_os    = stop_q || ts_stop || ((count_q != '0) && (os_cnt_inc == count_q));

`ifdef TS_OS_GEN_SKP_EN
    logic [CNT_W-1:0] skp_cnt;
    logic             end_q;
    logic             skp_due;

    assign skp_due = ((skp_cnt + 1'b1) == CNT_W'(SKP_INTERVAL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skp_cnt <= '0;
            end_q   <= 1'b0;
        end else if (accept) begin
            skp_cnt <= '0;
            end_q   <= 1'b0;
        end else if (os_end) begin
            skp_cnt <= skp_due ? '0 : skp_cnt + 1'b1;
            end_q   <= last_os;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (ts_start) state_nx = ST_SEND;
            ST_SEND: begin
                if (os_end) begin
`ifdef TS_OS_GEN_SKP_EN
                    if (skp_due)      state_nx = ST_SKP;
                    else if (last_os) state_nx = ST_DONE;
`else
                    if (last_os) state_nx = ST_DONE;
`endif
                end
            end
`ifdef TS_OS_GEN_SKP_EN
            ST_SKP:  if (fire && idx == SKP_LAST) state_nx = end_q ? ST_DONE : ST_SEND;
`endif
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            os_cnt <= '0;
            stop_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx    <= '0;
                os_cnt <= '0;
                stop_q <= 1'b0;
            end else begin
                if (sym_valid && ts_stop) stop_q <= 1'b1;
                if (fire) idx <= (state == ST_SKP && idx == SKP_LAST) ? '0 : idx + 1'b1;
                if (os_end) os_cnt <= os_cnt_inc;
            end
        end
    end

    // Run configuration is frozen at accept so mid-run input changes cannot corrupt a set.
    always_ff @(posedge clk) begin
        if (accept) begin
            type_q     <= ts_type;
            count_q    <= ts_count;
            link_q     <= link_num;
            link_pad_q <= link_pad;
            lane_pad_q <= lane_pad;
            lane_rev_q <= lane_rev;
            nfts_q     <= n_fts;
            rate_q     <= rate_id;
            ctl_q      <= train_ctl;
        end
    end

    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
        localparam logic [7:0] FWD_ID = 8'(i);
        localparam logic [7:0] REV_ID = 8'(LANE_NUM - 1 - i);
        logic [7:0] lane_data;
        logic       lane_k;

        ts_lane_sym u_sym (
            .idx       (idx),
            .skp_os    (state == ST_SKP),
            .ts_type   (type_q),
            .link_num  (link_q),
            .link_pad  (link_pad_q),
            .lane_pad  (lane_pad_q),
            .lane_id   (lane_rev_q ? REV_ID : FWD_ID),
            .n_fts     (nfts_q),
            .rate_id   (rate_q),
            .train_ctl (ctl_q),
            .data      (lane_data),
            .k         (lane_k)
        );

        assign sym_data[8*i +: 8] = sym_valid ? lane_data : 8'h00;
        assign sym_k[i]           = sym_valid && lane_k;
    end
endmodule

// File: tb/tb_ts_os_gen.sv
// Randomized bench for ts_os_gen: a beat-list model of the expected ordered-set stream is checked every cycle.
`timescale 1ns/1ps
module tb_ts_os_gen;
    localparam int LN = 4;
    localparam int CW = 16;
`ifdef TS_OS_GEN_SKP_EN
    localparam int IV = 2;
`else
    localparam int IV = 32;
`endif

    logic            clk, rst, ts_start, ts_type, ts_stop;
    logic [CW-1:0]   ts_count;
    logic [7:0]      link_num, n_fts, rate_id, train_ctl;
    logic            link_pad, lane_pad, lane_rev;
    logic            ts_busy, ts_done, sym_valid, sym_ready, sym_sos;
    logic [LN*8-1:0] sym_data;
    logic [LN-1:0]   sym_k;

    ts_os_gen #(.LANE_NUM(LN), .CNT_W(CW), .SKP_INTERVAL(IV)) dut (
        .clk(clk), .rst(rst), .ts_start(ts_start), .ts_type(ts_type), .ts_count(ts_count),
        .ts_stop(ts_stop), .link_num(link_num), .link_pad(link_pad), .lane_pad(lane_pad),
        .lane_rev(lane_rev), .n_fts(n_fts), .rate_id(rate_id), .train_ctl(train_ctl),
        .ts_busy(ts_busy), .ts_done(ts_done), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_data(sym_data), .sym_k(sym_k), .sym_sos(sym_sos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [LN*8-1:0] d;
        logic [LN-1:0]   k;
        logic            sos;
    } beat_t;

    beat_t  exp_q[$];
    int     os_of[$];
    int     total = 0, bad = 0;
    int     acc = 0, done_cnt = 0;
    logic   done_due = 1'b0;
    longint done_t = 0;

    logic       m_type, m_lpad, m_npad, m_rev;
    logic [7:0] m_link, m_nfts, m_rate, m_ctl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [8:0] ts_sym(input int s, input int lane);
        logic [7:0] lane_no;
        lane_no = m_rev ? 8'(LN - 1 - lane) : 8'(lane);
        case (s)
            0:       return {1'b1, 8'hBC};
            1:       return m_lpad ? {1'b1, 8'hF7} : {1'b0, m_link};
            2:       return m_npad ? {1'b1, 8'hF7} : {1'b0, lane_no};
            3:       return {1'b0, m_nfts};
            4:       return {1'b0, m_rate};
            5:       return {1'b0, m_ctl};
            default: return {1'b0, (m_type ? 8'h45 : 8'h4A)};
        endcase
    endfunction

    task automatic build(input int n_os);
        beat_t b;
        exp_q.delete();
        os_of.delete();
        for (int os = 0; os < n_os; os++) begin
            for (int s = 0; s < 16; s++) begin
                for (int l = 0; l < LN; l++) {b.k[l], b.d[l*8 +: 8]} = ts_sym(s, l);
                b.sos = (s == 0);
                exp_q.push_back(b);
                os_of.push_back(os);
            end
`ifdef TS_OS_GEN_SKP_EN
            if ((os + 1) % IV == 0) begin
                for (int s = 0; s < 4; s++) begin
                    for (int l = 0; l < LN; l++) {b.k[l], b.d[l*8 +: 8]} = {1'b1, (s == 0) ? 8'hBC : 8'h1C};
                    b.sos = (s == 0);
                    exp_q.push_back(b);
                    os_of.push_back(-1);
                end
            end
`endif
        end
    endtask

    task automatic set_cfg(input bit typ, input bit rev, input bit lpad, input bit npad, input logic [7:0] link);
        m_type = typ;  m_rev = rev;  m_lpad = lpad;  m_npad = npad;  m_link = link;
        m_nfts = 8'($urandom);  m_rate = 8'($urandom);  m_ctl = 8'($urandom);
    endtask

    // Every cycle: compare the presented beat against the head of the expected stream.
    always @(negedge clk) begin
        if (rst) begin
            done_due = 1'b0;
        end else begin
            chk("done_timing", ts_done, done_due);
            if (ts_done) begin
                done_cnt++;
                done_t = $time;
                chk("busy_at_done", ts_busy, 1'b1);
            end
            done_due = 1'b0;
            if (sym_valid) begin
                chk("busy_in_run", ts_busy, 1'b1);
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    chk("sym_data", sym_data, exp_q[0].d);
                    chk("sym_k", sym_k, exp_q[0].k);
                    chk("sym_sos", sym_sos, exp_q[0].sos);
                    if (sym_ready) begin
                        void'(exp_q.pop_front());
                        void'(os_of.pop_front());
                        acc++;
                        if (exp_q.size() == 0) done_due = 1'b1;
                    end
                end
            end
        end
    end

    // rmode: 0 ready held high, 1 toggles every cycle, 2 random (plus an ignored ts_start mid-run).
    task automatic run(input int cnt, input int stop_at, input int rmode, output int done_idx);
        int     s, n, cyc, d0;
        longint acc_t;
        ts_type = m_type;  lane_rev = m_rev;  link_pad = m_lpad;  lane_pad = m_npad;
        link_num = m_link; n_fts = m_nfts;    rate_id = m_rate;   train_ctl = m_ctl;
        ts_count = CW'(cnt);
        s = stop_at;
        if (stop_at < 0) begin
            build(cnt);
        end else begin
            build(stop_at / 16 + 2);
            while (os_of[s] < 0) s++;
            n = os_of[s] + 1;
            if (cnt != 0 && cnt < n) n = cnt;
            build(n);
        end
        acc = 0;
        d0 = done_cnt;
        done_idx = -1;
        @(posedge clk); #1;
        ts_start = 1'b1;
        sym_ready = (rmode == 2) ? 1'($urandom) : 1'b1;
        @(posedge clk);
        acc_t = $time;
        #1;
        ts_start = 1'b0;
        ts_type = ~ts_type;  ts_count = CW'($urandom);  link_num = 8'($urandom);
        lane_rev = ~lane_rev;  link_pad = ~link_pad;  lane_pad = ~lane_pad;
        n_fts = 8'($urandom);  rate_id = 8'($urandom);  train_ctl = 8'($urandom);
        cyc = 1;
        while (done_cnt == d0 && cyc < 3000) begin
            if (rmode == 1) sym_ready = ~sym_ready;
            else if (rmode == 2) sym_ready = 1'($urandom);
            ts_stop  = (stop_at >= 0) && (acc == s);
            ts_start = (rmode == 2) && (cyc == 6);
            @(posedge clk); #1;
            cyc++;
        end
        ts_stop = 1'b0;
        ts_start = 1'b0;
        sym_ready = 1'b1;
        chk("run_timeout", (done_cnt == d0) ? 1 : 0, 0);
        if (done_cnt != d0) done_idx = int'((done_t - 5 - acc_t) / 10) + 1;
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", done_cnt - d0, 1);
        chk("remaining_beats", exp_q.size(), 0);
        chk("idle_busy", ts_busy, 1'b0);
        chk("idle_valid", sym_valid, 1'b0);
    endtask

    int di, st, cn;

    initial begin
        rst = 1'b1;  ts_start = 1'b0;  ts_stop = 1'b0;  ts_type = 1'b0;  ts_count = '0;
        link_num = '0;  link_pad = 1'b0;  lane_pad = 1'b0;  lane_rev = 1'b0;
        n_fts = '0;  rate_id = '0;  train_ctl = '0;  sym_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {ts_busy, ts_done, sym_valid, sym_sos, sym_k, sym_data}, '0);
        rst = 1'b0;

        // TS1, two sets, lane numbers in order, ready held high.
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8'h05);
        build(2);
`ifdef TS_OS_GEN_SKP_EN
        chk("pin_len_c2", exp_q.size(), 36);
`else
        chk("pin_len_c2", exp_q.size(), 32);
`endif
        chk("pin_lane2_sym2", exp_q[2].d[23:16], 8'h02);
        chk("pin_sym1_link", exp_q[1].d[7:0], 8'h05);
        chk("pin_sym0_com", {exp_q[0].k, exp_q[0].d}, {4'hF, 32'hBCBCBCBC});
        run(2, -1, 0, di);
`ifdef TS_OS_GEN_SKP_EN
        chk("done_beat_idx", di, 37);
`else
        chk("done_beat_idx", di, 33);
`endif

        // TS2 with link and lane PAD.
        set_cfg(1'b1, 1'b0, 1'b1, 1'b1, 8'h33);
        build(1);
        chk("pin_pad_sym1", {exp_q[1].k, exp_q[1].d}, {4'hF, 32'hF7F7F7F7});
        chk("pin_pad_sym2", {exp_q[2].k, exp_q[2].d}, {4'hF, 32'hF7F7F7F7});
        chk("pin_ts2_id", {exp_q[9].k, exp_q[9].d}, {4'h0, 32'h45454545});
        run(1, -1, 0, di);

        // Ready toggling: stalled beats must hold; exactly one set accepted.
        set_cfg(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
        run(1, -1, 1, di);
        chk("stall_beats", acc, 16);

        // Continuous with stop at symbol 7 of the third set.
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        run(0, 39, 0, di);
`ifdef TS_OS_GEN_SKP_EN
        chk("stop_beats", acc, 52);
`else
        chk("stop_beats", acc, 48);
`endif

        // Stop on the final symbol-15 beat of a counted run.
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        run(2, 31, 0, di);
        chk("stop_last_beats", acc, 16 * 2 + ((IV == 2) ? 4 : 0));

        // ts_stop while idle has no effect on the following run.
        @(posedge clk); #1; ts_stop = 1'b1;
        @(posedge clk); #1; ts_stop = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8'h44);
        run(3, -1, 0, di);
        chk("idle_stop_beats", acc, 48 + ((IV == 2) ? 4 : 0));

        // Reset mid-set at symbol 9.
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        ts_type = 1'b0;  link_num = 8'h55;  ts_count = CW'(3);
        link_pad = 1'b0;  lane_pad = 1'b0;  lane_rev = 1'b0;
        n_fts = m_nfts;  rate_id = m_rate;  train_ctl = m_ctl;
        build(3);
        acc = 0;
        cn = done_cnt;
        @(posedge clk); #1; ts_start = 1'b1;
        @(posedge clk); #1; ts_start = 1'b0;
        st = 0;
        while (acc != 9 && st < 200) begin
            @(posedge clk); #1;
            st++;
        end
        chk("reset_wait_timeout", (acc == 9) ? 0 : 1, 0);
        rst = 1'b1;
        exp_q.delete();
        os_of.delete();
        @(posedge clk); #1;
        chk("mid_rst_outputs", {ts_busy, ts_done, sym_valid, sym_sos, sym_k, sym_data}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt - cn, 0);
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
        run(1, -1, 0, di);

`ifdef TS_OS_GEN_SKP_EN
        // SKP insertion every two sets, reversed lane numbering.
        set_cfg(1'b0, 1'b1, 1'b0, 1'b0, 8'h07);
        build(4);
        chk("pin_skp_len", exp_q.size(), 72);
        chk("pin_rev_lane0", exp_q[2].d[7:0], 8'h03);
        chk("pin_skp_com", {exp_q[32].sos, exp_q[32].k, exp_q[32].d}, {1'b1, 4'hF, 32'hBCBCBCBC});
        chk("pin_skp_sym", {exp_q[33].k, exp_q[33].d}, {4'hF, 32'h1C1C1C1C});
        run(4, -1, 0, di);
        chk("skp_beats", acc, 72);
`endif

        // Randomized runs.
        for (int it = 0; it < 8; it++) begin
            set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            cn = $urandom_range(0, 4);
            st = (cn == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 70)) : -1;
            run(cn, st, 2, di);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
